// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, legality check and the
// sequencer state type used by the bit-serial engine.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  // 001 and 111 have no defined slice behaviour and must never reach it.
  function automatic logic is_legal_op(input logic [2:0] code);
    return !(code == 3'b001 || code == 3'b111);
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Request/response bundle of the bit-serial ALU: operation request in,
// busy/done handshake plus result and flags out.
interface serial_alu_sequencer_if #(parameter int WIDTH = 64);
  logic             start;
  logic [2:0]       cntrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, cntrl, A, B,
    input  busy, done, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, cntrl, A, B,
    output busy, done, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/serial_alu_sequencer_bitslice.sv
// One-bit ALU slice: full adder with optional B inversion for subtract,
// plus bitwise AND/OR/XOR and pass-B.
module bitSlice import alu_pkg::*; (
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_t cntrl,
  output logic    result,
  output logic    cout
);

  logic b_eff;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result = 1'b0;
    cout   = 1'b0;
    b_eff  = (cntrl == ALU_SUB) ? ~b : b;
    case (cntrl)
      ALU_PASS_B: result = b;
      ALU_ADD, ALU_SUB: begin
        result = a ^ b_eff ^ cin;
        cout   = (a & b_eff) | (cin & (a ^ b_eff));
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: one WIDTH-bit operation over WIDTH RUN cycles through a
// single bitSlice, LSB first, with ARM-style N/Z/V/C flags.
module serial_alu_sequencer import alu_pkg::*; #(
  parameter int WIDTH = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  serial_alu_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] END_CNT  = CW'(WIDTH);

  seq_state_t       state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  alu_op_t          op;
  logic             carry, carry_msb_in;
  logic [CW-1:0]    cnt;
  logic             slice_res, slice_cout, arith;

  logic             busy_q, done_q, neg_q, zero_q, ovf_q, cout_q;
  logic [WIDTH-1:0] result_q;

  bitSlice u_slice (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry),
    .cntrl  (op),
    .result (slice_res),
    .cout   (slice_cout)
  );

  assign arith = (op == ALU_ADD) || (op == ALU_SUB);

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      r_sh         <= '0;
      op           <= ALU_PASS_B;
      carry        <= 1'b0;
      carry_msb_in <= 1'b0;
      cnt          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      neg_q        <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cout_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            a_sh   <= bus.A;
            r_sh   <= '0;
            cnt    <= '0;
            carry  <= (bus.cntrl == ALU_SUB);
            // Illegal codes degrade to pass-B of zero so the slice never sees them.
            if (is_legal_op(bus.cntrl)) begin
              op   <= alu_op_t'(bus.cntrl);
              b_sh <= bus.B;
            end else begin
              op   <= ALU_PASS_B;
              b_sh <= '0;
            end
          end
        end
        RUN: begin
          if (cnt == END_CNT) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= r_sh;
            neg_q    <= r_sh[WIDTH-1];
            zero_q   <= (r_sh == '0);
            ovf_q    <= arith & (carry_msb_in ^ carry);
            cout_q   <= arith & carry;
          end else begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {slice_res, r_sh[WIDTH-1:1]};
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_BIT) carry_msb_in <= carry;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_serial_alu_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 64;
  localparam int LAT   = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;   // {negative, zero, overflow, carry_out}
    int               due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] last_res = '0;

  serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] out_flags();
    return WIDTH'({bus.negative, bus.zero, bus.overflow, bus.carry_out});
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
    check("idle_timeout", WIDTH'(bus.busy), '0);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] res, input logic [3:0] f);
    exp_t e;
    e.res   = res;
    e.flags = f;
    e.due   = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic scramble_inputs();
    bus.A     = {$urandom(), $urandom()};
    bus.B     = {$urandom(), $urandom()};
    bus.cntrl = 3'($urandom_range(0, 7));
  endtask

  // Issue one op in the current IDLE cycle; returns once the engine is idle again.
  task automatic run_op(input logic [2:0] code, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic [3:0] exp_f);
    bus.start = 1'b1;
    bus.cntrl = code;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    push_exp(exp_res, exp_f);
    scramble_inputs();
    repeat (20) @(negedge clk);
    check("hold_result", bus.result, last_res);
    wait_idle();
    last_res = exp_res;
  endtask

  // Monitor: every done pulse must match the oldest expectation, on time, for one cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("spurious_done", WIDTH'(sb.size() > 0), WIDTH'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("flags_nzvc", out_flags(), WIDTH'(e.flags));
          check("latency", WIDTH'(cyc), WIDTH'(e.due));
        end
        @(negedge clk);
        check("done_width", WIDTH'(bus.done), '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.cntrl = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", WIDTH'(bus.busy), '0);
    check("rst_done", WIDTH'(bus.done), '0);
    check("rst_result", bus.result, '0);
    check("rst_flags", out_flags(), '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Arithmetic: flags are {N,Z,V,C}
    run_op(ALU_ADD, 64'd5, 64'd3, 64'd8, 4'b0000);
    run_op(ALU_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    run_op(ALU_SUB, 64'd5, 64'd5, 64'd0, 4'b0101);
    run_op(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    run_op(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010);

    // Logic, pass-B and illegal codes
    run_op(ALU_AND,    64'hF0F0, 64'hFF00, 64'hF000, 4'b0000);
    run_op(ALU_OR,     64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000);
    run_op(ALU_XOR,    64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000);
    run_op(ALU_PASS_B, 64'hF0F0, 64'hFF00, 64'hFF00, 4'b0000);
    run_op(3'b111,     64'hF0F0, 64'hFF00, 64'd0,    4'b0100);
    run_op(3'b001,     64'hF0F0, 64'hFF00, 64'd0,    4'b0100);

    // A second start during RUN must be ignored
    bus.start = 1'b1;
    bus.cntrl = ALU_ADD;
    bus.A     = 64'd5;
    bus.B     = 64'd3;
    @(negedge clk);
    bus.start = 1'b0;
    push_exp(64'd8, 4'b0000);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.cntrl = ALU_SUB;
    bus.A     = 64'd100;
    bus.B     = 64'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    last_res = 64'd8;
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse
    bus.start = 1'b1;
    bus.cntrl = ALU_ADD;
    bus.A     = 64'd9;
    bus.B     = 64'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    check("mid_run_busy", WIDTH'(bus.busy), WIDTH'(1));
    reset_n = 1'b0;
    #1;
    check("abort_busy", WIDTH'(bus.busy), '0);
    check("abort_done", WIDTH'(bus.done), '0);
    check("abort_result", bus.result, '0);
    check("abort_flags", out_flags(), '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last_res = '0;
    repeat (80) @(negedge clk);
    check("post_abort_busy", WIDTH'(bus.busy), '0);

    // Normal operation after reset
    run_op(ALU_ADD, 64'd1, 64'd2, 64'd3, 4'b0000);

    repeat (5) @(negedge clk);
    check("pending_expected", WIDTH'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
